// File: rtl/three_way_switch_debouncer_pkg.sv
// Shared definitions for the three-way switch debouncer: channel FSM
// state encoding, default debounce length and channel count.
package three_way_pkg;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_CHECK  = 1'b1
   } db_state_t;

   // 10 ms at 50 MHz.
   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int NUM_SWITCHES            = 3;

endpackage : three_way_pkg

// File: rtl/three_way_switch_debouncer_ch.sv
// One debounced switch channel: two-flop synchroniser, qualification
// counter and a two-state FSM. sw_db only changes after DEBOUNCE_CYCLES
// consecutive synchronised samples that differ from it.
module switch_debounce_ch
   import three_way_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw,
   output logic sw_db,
   output logic sw_toggle
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   db_state_t        state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             db_q,     db_d;
   logic             toggle_q, toggle_d;
   logic             accept;

   // The new level has been seen for the full qualification window.
   assign accept = (state_q == ST_CHECK) && (sync2_q != db_q) && (cnt_q == CNT_LAST);

   // State register: synchroniser chain, FSM state, counter and registered outputs.
   // NOTE: the reset is in the sensitivity list so assertion clears every flop at
   // once, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         state_q  <= ST_STABLE;
         cnt_q    <= '0;
         db_q     <= 1'b0;
         toggle_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge
         // values, so sync2_q really is one cycle behind sync1_q.
         sync1_q  <= sw_raw;
         sync2_q  <= sync1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         db_q     <= db_d;
         toggle_q <= toggle_d;
      end
   end

   // Next-state logic: count consecutive differing samples, abandon on any match.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latches.
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_STABLE: begin
            if (sync2_q != db_q) begin
               state_d = ST_CHECK;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         ST_CHECK: begin
            if (sync2_q == db_q) begin
               // Bounce back to the accepted level: restart from zero.
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               // Terminal compare comes before the increment, so no wrap.
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic: flip the accepted level and pulse toggle on qualification.
   always_comb begin
      db_d     = db_q;
      toggle_d = 1'b0;
      if (accept) begin
         db_d     = ~db_q;
         toggle_d = 1'b1;
      end
   end

   assign sw_db     = db_q;
   assign sw_toggle = toggle_q;

endmodule : switch_debounce_ch

// File: rtl/three_way_switch_debouncer.sv
// Front-end conditioning for the three-way light control: one independent
// debounce channel per switch plus an aggregate toggle pulse.
module three_way_switch_debouncer
   import three_way_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_SWITCHES-1:0] sw_raw,
   output logic [NUM_SWITCHES-1:0] sw_db,
   output logic [NUM_SWITCHES-1:0] sw_toggle,
   output logic                    any_toggle
);

   for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_ch
      switch_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .sw_raw    (sw_raw[i]),
         .sw_db     (sw_db[i]),
         .sw_toggle (sw_toggle[i])
      );
   end

   // Straight from the toggle registers: no extra cycle of latency.
   assign any_toggle = |sw_toggle;

endmodule : three_way_switch_debouncer

// File: doc/three_way_switch_debouncer.md
# three_way_switch_debouncer

- Front-end conditioning stage for the three-way light control.
- Takes three raw mechanical switch inputs and synchronises each to the system clock.
- Debounces each channel independently with a per-channel counter/FSM.
- Drives clean, glitch-free levels that feed the light-control function's `x1`/`x2`/`x3` inputs directly.
- Also emits a one-cycle toggle pulse per switch and an aggregate pulse for downstream logging or indicator logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000. Consecutive identical synchronised samples required to accept a new level (10 ms at 50 MHz). Legal range ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`. Counter width, derived; not overridden.

Ports:
- `clk`  input  1  single system clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronous to `clk` (handled by the integrator).
- `sw_raw`  input  3  raw, asynchronous switch levels. Bit 0 → `x1`, bit 1 → `x2`, bit 2 → `x3`.
- `sw_db`  output  3  debounced switch levels, registered.
- `sw_toggle`  output  3  one-cycle pulse per channel when its `sw_db` bit changes.
- `any_toggle`  output  1  OR of `sw_toggle`.

## Operation
- **Synchroniser:** two-flop chain per bit (`sync1` → `sync2`). No logic between the flops.
- **Per-channel FSM, states `ST_STABLE` and `ST_CHECK`:**
  - `ST_STABLE`: if `sync2 != sw_db`, go to `ST_CHECK` with `cnt = 1`; otherwise hold with `cnt = 0`.
  - `ST_CHECK`, sample returned to `sw_db`: go to `ST_STABLE`, `cnt = 0`. Bounce is rejected and there is no output change.
  - `ST_CHECK`, sample still differs and `cnt < DEBOUNCE_CYCLES-1`: increment `cnt`.
  - `ST_CHECK`, sample still differs and `cnt == DEBOUNCE_CYCLES-1`: invert `sw_db`, pulse `sw_toggle` for one cycle, go to `ST_STABLE`, `cnt = 0`.
- **Counter rules:**
  - Counter never wraps; the terminal compare precedes any increment.
  - Counter is unsigned, `CNT_W` bits.
- **Channel independence:** channels are fully independent. Simultaneous changes on several channels produce simultaneous `sw_toggle` bits, and `any_toggle` is a single pulse.
- **Reset (any time, including mid-count):**
  - Sync flops, `sw_db`, `cnt` and `sw_toggle` clear to 0; FSM goes to `ST_STABLE`.
  - A switch held high through reset is treated as a normal 0→1 change after release, producing a toggle pulse.

## Timing
Reset values:
- `sw_db` = 3'b000
- `sw_toggle` = 3'b000
- `any_toggle` = 0

Latency:
- Raw level first sampled at edge E. `sync2` updates at E+1.
- `sw_db` and `sw_toggle` update at E+1+`DEBOUNCE_CYCLES`, provided the level was stable throughout.

Pulse timing:
- `sw_toggle` is high for exactly one cycle, coincident with the `sw_db` change.
- `any_toggle` is combinational from the `sw_toggle` registers. It adds no extra cycle.

Filtering:
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised samples never reaches `sw_db`.
- Any sample equal to `sw_db` restarts qualification from zero.

Throughput:
- Minimum spacing between consecutive toggles on one channel is `DEBOUNCE_CYCLES` cycles.
- `sw_db` is not combinationally dependent on `sw_raw`.

## Structure
- **Shared package `three_way_pkg`:**
  - state typedef `db_state_t` {`ST_STABLE`, `ST_CHECK`}
  - constant `DEFAULT_DEBOUNCE_CYCLES` = 500000
  - constant `NUM_SWITCHES` = 3
- **Sub-module `switch_debounce_ch`:**
  - Holds one channel: 2-flop sync, counter and FSM.
  - Parameterised by `DEBOUNCE_CYCLES`.
  - Instantiated `NUM_SWITCHES` times in a generate loop.
  - Top level contains only the instances and the `any_toggle` OR.

## Test plan
Bench runs with `DEBOUNCE_CYCLES` = 4.
- **Reset values:** assert `rst_n` = 0 mid-simulation with a channel in `ST_CHECK` at `cnt` = 2 → all outputs read 0 immediately, with no clock edge needed.
- **Clean press:** hold `sw_raw[0]` 0→1, then stable → `sw_db` = 3'b001 exactly 5 edges after first sampling; `sw_toggle[0]` and `any_toggle` high for one cycle.
- **Bounce rejection:** `sw_raw[1]` toggles 1,0,1,0,1 at 1-cycle intervals, then holds 1 → no output change during the bounce; a single toggle 5 edges after the last transition.
- **Sub-threshold glitch:** `sw_raw[2]` pulses high for 3 cycles → `sw_db[2]` stays 0; `sw_toggle` never asserts.
- **Simultaneous changes:** `sw_raw` 3'b000→3'b111 in the same cycle → `sw_db` = 3'b111 at the same edge; `sw_toggle` = 3'b111 for one cycle; `any_toggle` is a single one-cycle pulse.
- **Release and repeat:** `sw_raw[0]` 1→0 after a stable high → `sw_db[0]` returns to 0 after 5 edges with one pulse; hold for 20 cycles → no further pulses.
